// File: rtl/adc_packet_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_packet_framer_pkg
// Brief   : Shared frame definitions for the ADC framer and the host parser.
// Revision: 1.0 - initial release
// ============================================================================
package adc_packet_framer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SYNC      = 4'd1,
        ST_LEN_HI    = 4'd2,
        ST_LEN_LO    = 4'd3,
        ST_SEQ       = 4'd4,
        ST_FETCH     = 4'd5,
        ST_WAIT_DATA = 4'd6,
        ST_SEND_DATA = 4'd7,
        ST_CHECKSUM  = 4'd8,
        ST_DONE      = 4'd9
    } state_t;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

    // Byte offsets of each field within a frame; checksum follows the payload.
    localparam int C_FIELD_SYNC    = 0;
    localparam int C_FIELD_LEN_HI  = 1;
    localparam int C_FIELD_LEN_LO  = 2;
    localparam int C_FIELD_SEQ     = 3;
    localparam int C_FIELD_PAYLOAD = 4;
    localparam int C_HEADER_BYTES  = 4;

endpackage
`default_nettype wire

// File: rtl/adc_packet_framer_tx_byte_handshake.sv
`default_nettype none
// ============================================================================
// Module  : adc_packet_framer_tx_byte_handshake
// Brief   : Issues one-cycle TxStart pulses with a busy-ignore guard cycle.
// Revision: 1.0 - initial release
// ============================================================================
module adc_packet_framer_tx_byte_handshake (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_send,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic       o_accepted,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data
);

    logic       r_tx_start;
    logic       r_guard;
    logic [7:0] r_tx_data;
    logic       w_issue;

    // The UART may only raise busy a cycle after start, so the cycle after a
    // start is never trusted as idle.
    assign w_issue = i_send && !r_tx_start && !r_guard && !i_tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_guard    <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_guard    <= r_tx_start;
            r_tx_start <= w_issue;
            if (w_issue) begin
                r_tx_data <= i_byte;
            end
        end
    end

    assign o_accepted = r_tx_start;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: rtl/adc_packet_framer.sv
`default_nettype none
// ============================================================================
// Module  : adc_packet_framer
// Brief   : Wraps storage bytes into sync/len/seq/payload/checksum frames.
// Revision: 1.0 - initial release
// ============================================================================
module adc_packet_framer
    import adc_packet_framer_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = C_SYNC_BYTE,
    parameter logic [15:0] PAYLOAD_LEN    = 16'd1024,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic [7:0] i_adc_data,
    input  logic       i_adc_data_valid,
    output logic       o_adc_data_strobe,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_busy,
    output logic       o_frame_active,
    output logic       o_frame_done,
    output logic       o_underflow
);

    state_t      r_state;
    logic [15:0] r_byte_cnt;
    logic [19:0] r_timeout;
    logic [7:0]  r_seq;
    logic [7:0]  r_checksum;
    logic [7:0]  r_payload;
    logic        r_strobe;
    logic        r_active;
    logic        r_done;
    logic        r_underflow;

    logic        w_send;
    logic [7:0]  w_byte;
    logic        w_accepted;
    logic [15:0] w_cnt_next;

    assign w_cnt_next = r_byte_cnt + 16'd1;

    always_comb begin
        w_send = 1'b1;
        w_byte = 8'h00;
        case (r_state)
            ST_SYNC:      w_byte = SYNC_BYTE;
            ST_LEN_HI:    w_byte = PAYLOAD_LEN[15:8];
            ST_LEN_LO:    w_byte = PAYLOAD_LEN[7:0];
            ST_SEQ:       w_byte = r_seq;
            ST_SEND_DATA: w_byte = r_payload;
            ST_CHECKSUM:  w_byte = r_checksum;
            default:      w_send = 1'b0;
        endcase
    end

    adc_packet_framer_tx_byte_handshake u_tx_byte_handshake (
        .clk        (clk),
        .rst        (rst),
        .i_send     (w_send),
        .i_byte     (w_byte),
        .i_tx_busy  (i_tx_busy),
        .o_accepted (w_accepted),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= 16'd0;
            r_timeout   <= 20'd0;
            r_seq       <= 8'd0;
            r_checksum  <= 8'd0;
            r_payload   <= 8'd0;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_enable && i_adc_data_valid) begin
                        r_state     <= ST_SYNC;
                        r_active    <= 1'b1;
                        r_underflow <= 1'b0;
                        r_byte_cnt  <= 16'd0;
                        r_checksum  <= 8'd0;
                        r_timeout   <= 20'd0;
                    end
                end
                ST_SYNC:   if (w_accepted) r_state <= ST_LEN_HI;
                ST_LEN_HI: if (w_accepted) r_state <= ST_LEN_LO;
                ST_LEN_LO: if (w_accepted) r_state <= ST_SEQ;
                ST_SEQ:    if (w_accepted) r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (i_adc_data_valid) begin
                        r_strobe <= 1'b1;
                        r_state  <= ST_WAIT_DATA;
                    end else if (r_timeout == TIMEOUT_CYCLES - 20'd1) begin
                        r_payload   <= 8'h00;
                        r_underflow <= 1'b1;
                        r_state     <= ST_SEND_DATA;
                    end else begin
                        r_timeout <= r_timeout + 20'd1;
                    end
                end
                // Storage sees the pop on the edge ending the strobe cycle, so
                // its data is only valid once the strobe has dropped.
                ST_WAIT_DATA: begin
                    if (!r_strobe) begin
                        r_payload <= i_adc_data;
                        r_state   <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_accepted) begin
                        r_checksum <= r_checksum ^ r_payload;
                        r_byte_cnt <= w_cnt_next;
                        if (w_cnt_next == PAYLOAD_LEN) begin
                            r_state <= ST_CHECKSUM;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_timeout <= 20'd0;
                        end
                    end
                end
                ST_CHECKSUM: if (w_accepted) r_state <= ST_DONE;
                ST_DONE: begin
                    r_done   <= 1'b1;
                    r_seq    <= r_seq + 8'd1;
                    r_active <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_adc_data_strobe = r_strobe;
    assign o_frame_active    = r_active;
    assign o_frame_done      = r_done;
    assign o_underflow       = r_underflow;

endmodule
`default_nettype wire
